// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and the pipeline registers
// built from if_id_reg. FETCH_ALIGN_CHECK_EN adds the address-error flag to
// the IF/ID slot payload.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          IM_AW_DEFAULT    = 12;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] LINK_OFFSET      = 32'd8;

  // Part of IF/ID that is cleared to a bubble by a flush. An all-zero value
  // is the bubble: nop instruction, not valid, no exception.
  typedef struct packed {
`ifdef FETCH_ALIGN_CHECK_EN
    logic        exc_adel;
`endif
    logic        valid;
    logic [31:0] instr;
  } ifid_slot_t;

  // Part of IF/ID that is never cleared; the link value is carried as its
  // own register so D never adds 8 in its own timing path.
  typedef struct packed {
    logic [31:0] pc8;
    logic [31:0] pc;
  } ifid_pc_t;

  // Word offset of a PC from the instruction-memory base. Addresses below
  // the base simply wrap.
  function automatic logic [31:0] pc_word_offset(input logic [31:0] pc,
                                                 input logic [31:0] base);
    return (pc - base) >> 2;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: IM read port, hazard and
// redirect controls from D, and the IF/ID outputs. FETCH_ALIGN_CHECK_EN adds
// D_exc_adel.
interface fetch_stage_if #(
  parameter int IM_AW = 12
);
  logic [IM_AW-1:0] im_widx;
  logic [31:0]      im_rdata;
  logic             stall;
  logic             flush;
  logic             redir_valid;
  logic [31:0]      redir_target;
  logic [31:0]      F_pc;
  logic [31:0]      D_instr;
  logic [31:0]      D_pc;
  logic [31:0]      D_pc8;
  logic             D_valid;
  logic [31:0]      fetch_cnt;
`ifdef FETCH_ALIGN_CHECK_EN
  logic             D_exc_adel;
`endif

  // Fetch stage side.
  modport slave (
    output im_widx,
    input  im_rdata,
    input  stall,
    input  flush,
    input  redir_valid,
    input  redir_target,
    output F_pc,
    output D_instr,
    output D_pc,
    output D_pc8,
    output D_valid,
    output fetch_cnt
`ifdef FETCH_ALIGN_CHECK_EN
    , output D_exc_adel
`endif
  );

  // Memory / hazard unit / decode side.
  modport master (
    input  im_widx,
    output im_rdata,
    output stall,
    output flush,
    output redir_valid,
    output redir_target,
    input  F_pc,
    input  D_instr,
    input  D_pc,
    input  D_pc8,
    input  D_valid,
    input  fetch_cnt
`ifdef FETCH_ALIGN_CHECK_EN
    , input D_exc_adel
`endif
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with hold and clear. The payload is split into a
// clearable slot (zeroed by clear, zero at reset) and a kept part that only
// loads when not held. Used for IF/ID and intended for D/E and E/M.
module if_id_reg #(
  parameter int              CW    = 33,
  parameter int              KW    = 64,
  parameter logic [KW-1:0]   K_RST = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_hold,
  input  logic          i_clear,
  input  logic [CW-1:0] i_cdata,
  input  logic [KW-1:0] i_kdata,
  output logic [CW-1:0] o_cdata,
  output logic [KW-1:0] o_kdata
);

  logic [CW-1:0] r_cdata;
  logic [KW-1:0] r_kdata;

  // Hold freezes everything except a concurrent clear of the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cdata <= '0;
      r_kdata <= K_RST;
    end else if (i_hold) begin
      if (i_clear) begin
        r_cdata <= '0;
      end
    end else begin
      r_kdata <= i_kdata;
      r_cdata <= i_clear ? '0 : i_cdata;
    end
  end

  assign o_cdata = r_cdata;
  assign o_kdata = r_kdata;

endmodule

// File: rtl/fetch_stage.sv
// F stage of the five-stage MIPS pipeline with delayed branches: PC register,
// IM addressing, stall/flush/redirect handling, IF/ID register and fetch
// counter. Optional macro FETCH_ALIGN_CHECK_EN turns fetches from unaligned
// PCs into address-error bubbles flagged on D_exc_adel.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IM_AW    = IM_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam logic [63:0] PC_RST = {RESET_PC + LINK_OFFSET, RESET_PC};

  logic [31:0] r_pc;
  logic [31:0] r_fetch_cnt;
  logic [31:0] w_next_pc;
  logic        w_unaligned;
  logic        w_count_en;
  ifid_slot_t  w_slot_d;
  ifid_slot_t  w_slot_q;
  ifid_pc_t    w_pcs_d;
  ifid_pc_t    w_pcs_q;

  // Redirect wins over sequential fetch; PC arithmetic wraps silently.
  assign w_next_pc = bus.redir_valid ? bus.redir_target : r_pc + PC_STEP;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_unaligned = |r_pc[1:0];
`else
  assign w_unaligned = 1'b0;
`endif

  // Word index ignores PC[1:0]; unaligned PCs fetch the truncated word.
  assign bus.im_widx = IM_AW'(pc_word_offset(r_pc, RESET_PC));

  // Build the IF/ID load value; an unaligned fetch becomes a flagged bubble.
  always_comb begin
    w_slot_d       = '0;
    w_slot_d.instr = w_unaligned ? NOP_INSTR : bus.im_rdata;
    w_slot_d.valid = ~w_unaligned;
`ifdef FETCH_ALIGN_CHECK_EN
    w_slot_d.exc_adel = w_unaligned;
`endif
    w_pcs_d.pc     = r_pc;
    w_pcs_d.pc8    = r_pc + LINK_OFFSET;
  end

  // PC freezes on stall; redirects during a stall are re-sent by D later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!bus.stall) begin
      r_pc <= w_next_pc;
    end
  end

  // Only real instructions entering IF/ID are counted.
  assign w_count_en = ~bus.stall & ~bus.flush & ~w_unaligned;

  // Fetch counter, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
    end else if (w_count_en) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  if_id_reg #(
    .CW    ($bits(ifid_slot_t)),
    .KW    ($bits(ifid_pc_t)),
    .K_RST (PC_RST)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_hold  (bus.stall),
    .i_clear (bus.flush),
    .i_cdata (w_slot_d),
    .i_kdata (w_pcs_d),
    .o_cdata (w_slot_q),
    .o_kdata (w_pcs_q)
  );

  assign bus.F_pc      = r_pc;
  assign bus.D_instr   = w_slot_q.instr;
  assign bus.D_valid   = w_slot_q.valid;
  assign bus.D_pc      = w_pcs_q.pc;
  assign bus.D_pc8     = w_pcs_q.pc8;
  assign bus.fetch_cnt = r_fetch_cnt;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.D_exc_adel = w_slot_q.exc_adel;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/flush/redirect/reset traffic, compared against a behavioural model of
// the fetch rules. Honours FETCH_ALIGN_CHECK_EN when defined.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int          AW  = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_stage_if #(.IM_AW(AW)) u_if ();

  fetch_stage #(.RESET_PC(RPC), .IM_AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Instruction memory model, read combinationally at the DUT's index.
  logic [31:0] imem [0:4095];
  assign u_if.im_rdata = imem[u_if.im_widx];

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
  logic        m_valid, m_exc;

  int n_checks = 0;
  int n_err    = 0;
  int n_step   = 0;

  function automatic logic [AW-1:0] widx_of(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - RPC) >> 2;
    return off[AW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch rules, highest priority first.
  task automatic model_edge(input logic rs, input logic st, input logic fl,
                            input logic rv, input logic [31:0] rt);
    logic [31:0] fetched;
    logic        unal;
    if (rs) begin
      m_pc = RPC; m_instr = 32'h0; m_dpc = RPC; m_valid = 1'b0; m_cnt = 32'h0; m_exc = 1'b0;
    end else if (st) begin
      if (fl) begin
        m_instr = 32'h0; m_valid = 1'b0; m_exc = 1'b0;
      end
    end else begin
      fetched = imem[widx_of(m_pc)];
`ifdef FETCH_ALIGN_CHECK_EN
      unal = (m_pc[1:0] != 2'b00);
`else
      unal = 1'b0;
`endif
      m_dpc = m_pc;
      if (fl) begin
        m_instr = 32'h0; m_valid = 1'b0; m_exc = 1'b0;
      end else if (unal) begin
        m_instr = 32'h0; m_valid = 1'b0; m_exc = 1'b1;
      end else begin
        m_instr = fetched; m_valid = 1'b1; m_exc = 1'b0; m_cnt = m_cnt + 32'd1;
      end
      m_pc = rv ? rt : m_pc + 32'd4;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "/F_pc"},      u_if.F_pc,            m_pc);
    check({tag, "/im_widx"},   32'(u_if.im_widx),    32'(widx_of(m_pc)));
    check({tag, "/D_instr"},   u_if.D_instr,         m_instr);
    check({tag, "/D_pc"},      u_if.D_pc,            m_dpc);
    check({tag, "/D_pc8"},     u_if.D_pc8,           m_dpc + 32'd8);
    check({tag, "/D_valid"},   32'(u_if.D_valid),    32'(m_valid));
    check({tag, "/fetch_cnt"}, u_if.fetch_cnt,       m_cnt);
`ifdef FETCH_ALIGN_CHECK_EN
    check({tag, "/D_exc_adel"}, 32'(u_if.D_exc_adel), 32'(m_exc));
`endif
  endtask

  task automatic step(input logic rs, input logic st, input logic fl,
                      input logic rv, input logic [31:0] rt, input string tag);
    @(negedge clk);
    reset             = rs;
    u_if.stall        = st;
    u_if.flush        = fl;
    u_if.redir_valid  = rv;
    u_if.redir_target = rt;
    model_edge(rs, st, fl, rv, rt);
    @(posedge clk);
    #1;
    compare_model(tag);
    n_step++;
    $display("step %0d %s rs=%0b st=%0b fl=%0b rv=%0b rt=%h F_pc=%h D_pc=%h D_instr=%h D_valid=%0b cnt=%0d",
             n_step, tag, rs, st, fl, rv, rt, u_if.F_pc, u_if.D_pc, u_if.D_instr,
             u_if.D_valid, u_if.fetch_cnt);
  endtask

  logic [31:0] saved;

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = $urandom;
    imem[0] = 32'h3421_0005;
    u_if.stall = 1'b0; u_if.flush = 1'b0; u_if.redir_valid = 1'b0; u_if.redir_target = 32'h0;
    m_pc = RPC; m_instr = 32'h0; m_dpc = RPC; m_valid = 1'b0; m_cnt = 32'h0; m_exc = 1'b0;

    // Reset state.
    step(1, 0, 0, 0, 32'h0, "reset");
    step(1, 0, 0, 0, 32'h0, "reset");
    check("rst_F_pc",    u_if.F_pc,             32'h0000_3000);
    check("rst_D_pc8",   u_if.D_pc8,            32'h0000_3008);
    check("rst_D_valid", 32'(u_if.D_valid),     32'h0);
    check("rst_cnt",     u_if.fetch_cnt,        32'h0);

    // Reset release: first instruction is ori.
    step(0, 0, 0, 0, 32'h0, "release");
    check("rel_F_pc",    u_if.F_pc,             32'h0000_3004);
    check("rel_D_instr", u_if.D_instr,          32'h3421_0005);
    check("rel_D_pc",    u_if.D_pc,             32'h0000_3000);
    check("rel_D_pc8",   u_if.D_pc8,            32'h0000_3008);
    check("rel_cnt",     u_if.fetch_cnt,        32'h1);
    check("rel_ori",     32'(u_if.D_instr[31:26] == 6'h0D && u_if.D_valid), 32'h1);

    // Straight-line fetch, 8 cycles total.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 32'h0, "line");
    check("line_F_pc", u_if.F_pc,      32'h0000_3020);
    check("line_D_pc", u_if.D_pc,      32'h0000_301C);
    check("line_cnt",  u_if.fetch_cnt, 32'h8);

    // Stall for 3 cycles at F_pc=0x3010.
    step(1, 0, 0, 0, 32'h0, "reset");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h0, "pre_stall");
    saved = u_if.D_instr;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 32'h0, "stall");
      check("stall_F_pc",    u_if.F_pc,      32'h0000_3010);
      check("stall_D_instr", u_if.D_instr,   saved);
      check("stall_cnt",     u_if.fetch_cnt, 32'h4);
    end
    step(0, 0, 0, 0, 32'h0, "resume");
    check("resume_F_pc", u_if.F_pc,      32'h0000_3014);
    check("resume_cnt",  u_if.fetch_cnt, 32'h5);

    // Redirect with delay slot.
    step(1, 0, 0, 0, 32'h0, "reset");
    step(0, 0, 0, 0, 32'h0, "pre_redir");
    step(0, 0, 0, 0, 32'h0, "pre_redir");
    step(0, 0, 0, 1, 32'h0000_3100, "redir");
    check("redir_F_pc",    u_if.F_pc,          32'h0000_3100);
    check("redir_D_pc",    u_if.D_pc,          32'h0000_3008);
    check("redir_D_valid", 32'(u_if.D_valid),  32'h1);

    // Stall and flush together, then resume from the same PC.
    step(0, 1, 1, 0, 32'h0, "stall_flush");
    check("sf_F_pc",    u_if.F_pc,         32'h0000_3100);
    check("sf_D_valid", 32'(u_if.D_valid), 32'h0);
    check("sf_D_instr", u_if.D_instr,      32'h0);
    check("sf_D_pc",    u_if.D_pc,         32'h0000_3008);
    step(0, 0, 0, 0, 32'h0, "sf_resume");
    check("sfr_D_pc", u_if.D_pc, 32'h0000_3100);

    // Flush alone with redirect; redirect ignored under stall.
    step(0, 0, 1, 1, 32'h0000_3200, "flush");
    check("fl_F_pc", u_if.F_pc, 32'h0000_3200);
    step(0, 1, 0, 1, 32'h0000_3300, "stall_redir");
    check("sr_F_pc", u_if.F_pc, 32'h0000_3200);

    // PC wrap and index below the base.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, "to_top");
    step(0, 0, 0, 0, 32'h0, "wrap");
    check("wrap_F_pc",  u_if.F_pc,           32'h0);
    check("wrap_widx",  32'(u_if.im_widx),   32'h400);

    // Unaligned redirect.
    step(0, 0, 0, 1, 32'h0000_3102, "unal_redir");
    saved = u_if.fetch_cnt;
    step(0, 0, 0, 0, 32'h0, "unal_fetch");
`ifdef FETCH_ALIGN_CHECK_EN
    check("adel_flag",  32'(u_if.D_exc_adel), 32'h1);
    check("adel_valid", 32'(u_if.D_valid),    32'h0);
    check("adel_cnt",   u_if.fetch_cnt,       saved);
`else
    check("unal_D_instr", u_if.D_instr,   imem[12'h040]);
    check("unal_cnt",     u_if.fetch_cnt, saved + 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        rs, st, fl, rv;
      logic [31:0] rt;
      rs = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 6) == 0);
      rv = ($urandom_range(0, 5) == 0);
      rt = RPC + (32'($urandom_range(0, 4095)) << 2);
      if ($urandom_range(0, 7) == 0) rt = rt + 32'($urandom_range(1, 3));
      step(rs, st, fl, rv, rt, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
